flow_table_assoc: RTL and testbench
===================================

Name: flow_table_assoc

Overview:
- Parametrised N-way set-associative exact-match flow table for the match-action stage.
- Maps a KEY_W-bit flow key to an ID_W-bit flow id.
- Lookups are fully pipelined with valid/ready, one per cycle, fixed latency.
- PS programs entries word-wise through a staging register plus explicit commit.
- Block self-flushes after reset and on request, and keeps saturating hit/miss counters.

Parameters:
- KEY_W, 128, key width; multiple of 32 and of INDEX_W.
- ID_W, 16, flow id width; 1..31.
- INDEX_W, 8, set index width; SETS = 2**INDEX_W.
- WAYS, 2, associativity; 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- lookup_valid  in  1  lookup request
- lookup_ready  out  1  block can accept a lookup
- lookup_key  in  KEY_W  key to match
- res_valid  out  1  result strobe
- res_hit  out  1  key matched a valid entry
- res_id  out  ID_W  id of matching entry; 0 on miss
- res_way  out  $clog2(WAYS)+1  matching way; 0 on miss
- cfg_we  in  1  write one staging word
- cfg_word  in  $clog2(KEY_W/32+1)  staging word select
- cfg_wdata  in  32  staging data
- cfg_commit  in  1  write staging register into table
- cfg_set  in  INDEX_W  target set for commit
- cfg_way  in  $clog2(WAYS)+1  target way for commit
- cfg_flush  in  1  request invalidation of all entries
- cfg_cnt_clr  in  1  clear hit/miss counters
- cfg_busy  out  1  flush in progress
- cfg_err  out  1  one-cycle pulse when a commit is dropped
- hit_cnt  out  32  saturating hit count
- miss_cnt  out  32  saturating miss count

Behaviour:
- Reset: all outputs 0 except cfg_busy=1. Counters and staging register cleared. FSM enters FLUSH.
- Hash: index = XOR of all INDEX_W-bit chunks of lookup_key.
- FSM IDLE: lookup_ready=1, cfg_busy=0. cfg_flush goes to FLUSH.
- FSM FLUSH: lookup_ready=0, cfg_busy=1.
  - A counter walks sets 0..SETS-1, clearing the valid bit of every way, one set per cycle.
  - After SETS cycles, returns to IDLE.
  - cfg_flush while already in FLUSH is ignored.
- Lookup is accepted when lookup_valid && lookup_ready (cycle 0).
  - Cycle 1: set read.
  - Cycle 2: parallel compare across all ways.
  - res_valid asserts in cycle 3.
  - One result per accepted lookup, in order, back-to-back throughput 1/cycle.
  - Lookups accepted before a flush still complete with their results.
- Multiple ways match: the lowest-numbered way wins.
- Staging register: cfg_word k < KEY_W/32 loads key bits [32k+31:32k]. cfg_word = KEY_W/32 loads {valid = wdata[ID_W], id = wdata[ID_W-1:0]}. Other cfg_word values are ignored.
- cfg_commit writes the staging entry to (cfg_set, cfg_way) on the next clock edge. The staging register is retained, so repeated commits are allowed.
  - Commit with cfg_way >= WAYS: dropped, cfg_err pulses.
  - Commit during FLUSH: dropped, cfg_err pulses.
- cfg_we and cfg_commit in the same cycle: the commit uses the old staging contents.
- Read/write hazard: a lookup whose set read happens in the commit cycle for the same set sees the old entry (read-first). Lookups read one cycle later see the new entry.
- Counters: on every res_valid, increment hit_cnt or miss_cnt, saturating at 32'hFFFF_FFFF.
  - cfg_cnt_clr coinciding with res_valid: clear wins.
- Reset mid-lookup: in-flight results are discarded (no res_valid) and a flush restarts.

Test Plan:
- Reset, hold lookup_valid=1 -> lookup_ready=0 and cfg_busy=1 for 256 cycles, then ready=1. First lookup of any key -> res_valid 3 cycles later, res_hit=0, miss_cnt=1.
- Stage key 128'h42, word 4 = 32'h1_0007, commit set 8'h42 way 0; look up 128'h42 -> res_hit=1, res_id=16'h0007, res_way=0, latency 3.
- Collision: commit key 128'h4200 (also hashes to 8'h42) with id 16'h0009 into way 1 -> both keys hit with ids 7 and 9. Key 128'h4242 (hash 0) misses.
- Back-to-back: 10 alternating hit/miss lookups on consecutive cycles -> 10 in-order results on consecutive cycles; hit_cnt += 5, miss_cnt += 5.
- Commit to cfg_way=2 with WAYS=2, and a commit issued during flush -> each pulses cfg_err for 1 cycle; the table is unchanged.
- Program an entry, pulse cfg_flush -> 256 busy cycles, then lookup of the programmed key -> res_hit=0. cfg_cnt_clr together with res_valid -> counters read 0.

Source files
------------

// File: rtl/flow_table_assoc.sv
// N-way set-associative exact-match flow table: key -> flow id.
// Ports: lookup_* (valid/ready request), res_* (3-cycle result),
//        cfg_* (staging writes, commit, flush, counter clear), hit/miss counters.
module flow_table_assoc #(
    parameter int KEY_W   = 128,
    parameter int ID_W    = 16,
    parameter int INDEX_W = 8,
    parameter int WAYS    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            lookup_valid,
    output logic                            lookup_ready,
    input  logic [KEY_W-1:0]                lookup_key,
    output logic                            res_valid,
    output logic                            res_hit,
    output logic [ID_W-1:0]                 res_id,
    output logic [$clog2(WAYS):0]           res_way,
    input  logic                            cfg_we,
    input  logic [$clog2(KEY_W/32+1)-1:0]   cfg_word,
    input  logic [31:0]                     cfg_wdata,
    input  logic                            cfg_commit,
    input  logic [INDEX_W-1:0]              cfg_set,
    input  logic [$clog2(WAYS):0]           cfg_way,
    input  logic                            cfg_flush,
    input  logic                            cfg_cnt_clr,
    output logic                            cfg_busy,
    output logic                            cfg_err,
    output logic [31:0]                     hit_cnt,
    output logic [31:0]                     miss_cnt
);

    localparam int SETS   = 2**INDEX_W;
    localparam int WAY_W  = $clog2(WAYS) + 1;
    localparam int NWORDS = KEY_W / 32;
    localparam int WORD_W = $clog2(KEY_W/32 + 1);
    localparam int NCHUNK = KEY_W / INDEX_W;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [INDEX_W-1:0]   flush_cnt;

    logic [KEY_W-1:0]     stage_key;
    logic [ID_W-1:0]      stage_id;
    logic                 stage_vld;

    logic [KEY_W-1:0]     key_mem [WAYS][SETS];
    logic [ID_W-1:0]      id_mem  [WAYS][SETS];
    logic [SETS-1:0]      vld_mem [WAYS];

    logic                 accept;
    logic                 way_bad;
    logic                 commit_ok;

    logic                 s1_v;
    logic [KEY_W-1:0]     s1_key;
    logic [INDEX_W-1:0]   s1_idx;

    logic                 s2_v;
    logic [KEY_W-1:0]     s2_lkey;
    logic [KEY_W-1:0]     s2_key [WAYS];
    logic [ID_W-1:0]      s2_id  [WAYS];
    logic [WAYS-1:0]      s2_vld;

    logic                 cmp_hit;
    logic [ID_W-1:0]      cmp_id;
    logic [WAY_W-1:0]     cmp_way;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FLUSH;
            flush_cnt <= '0;
        end else begin
            state_q   <= state_d;
            flush_cnt <= (state_q == FLUSH) ? flush_cnt + INDEX_W'(1) : '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        lookup_ready = 1'b0;
        cfg_busy     = 1'b0;
        unique case (state_q)
            IDLE: begin
                lookup_ready = 1'b1;
                if (cfg_flush) state_d = FLUSH;
            end
            FLUSH: begin
                cfg_busy = 1'b1;
                if (flush_cnt == '1) state_d = IDLE;
            end
        endcase
    end

    assign accept    = lookup_valid && lookup_ready;
    assign way_bad   = cfg_way >= WAY_W'(WAYS);
    assign commit_ok = cfg_commit && !rst && (state_q == IDLE) && !way_bad;

    // ---------------- staging register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_key <= '0;
            stage_id  <= '0;
            stage_vld <= 1'b0;
        end else if (cfg_we) begin
            for (int k = 0; k < NWORDS; k++) begin
                if (cfg_word == WORD_W'(k)) stage_key[32*k +: 32] <= cfg_wdata;
            end
            if (cfg_word == WORD_W'(NWORDS)) begin
                stage_vld <= cfg_wdata[ID_W];
                stage_id  <= cfg_wdata[ID_W-1:0];
            end
        end
    end

    // ---------------- table storage ----------------
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (commit_ok && cfg_way == WAY_W'(w)) begin
                key_mem[w][cfg_set] <= stage_key;
                id_mem[w][cfg_set]  <= stage_id;
            end
        end
    end

    // Valid bits are kept apart from key/id so a flush can clear one set
    // per cycle; commits are refused while flushing, so the two never collide.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (state_q == FLUSH) vld_mem[w][flush_cnt] <= 1'b0;
            if (commit_ok && cfg_way == WAY_W'(w)) vld_mem[w][cfg_set] <= stage_vld;
        end
    end

    // ---------------- lookup pipeline ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= accept;
            s2_v <= s1_v;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) s1_key <= lookup_key;
    end

    always_comb begin
        s1_idx = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            s1_idx = s1_idx ^ s1_key[c*INDEX_W +: INDEX_W];
        end
    end

    // Registered read: a commit on the same edge is not yet visible here.
    always_ff @(posedge clk) begin
        s2_lkey <= s1_key;
        for (int w = 0; w < WAYS; w++) begin
            s2_key[w] <= key_mem[w][s1_idx];
            s2_id[w]  <= id_mem[w][s1_idx];
            s2_vld[w] <= vld_mem[w][s1_idx];
        end
    end

    // Scan downward so the lowest matching way is the one left standing.
    always_comb begin
        cmp_hit = 1'b0;
        cmp_id  = '0;
        cmp_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (s2_vld[w] && s2_key[w] == s2_lkey) begin
                cmp_hit = 1'b1;
                cmp_id  = s2_id[w];
                cmp_way = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_hit   <= 1'b0;
            res_id    <= '0;
            res_way   <= '0;
        end else begin
            res_valid <= s2_v;
            res_hit   <= s2_v && cmp_hit;
            res_id    <= s2_v ? cmp_id : '0;
            res_way   <= s2_v ? cmp_way : '0;
        end
    end

    // ---------------- counters and error strobe ----------------
    always_ff @(posedge clk) begin
        if (rst || cfg_cnt_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (res_valid) begin
            if (res_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            if (!res_hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cfg_err <= 1'b0;
        else     cfg_err <= cfg_commit && (state_q != IDLE || way_bad);
    end

endmodule

// File: tb/tb_flow_table_assoc.sv
// Randomised + directed bench for flow_table_assoc against a table model.
// Ports: none (top-level testbench).
module tb_flow_table_assoc;

    localparam int KW = 128;
    localparam int IW = 16;
    localparam int XW = 8;
    localparam int NW = 2;
    localparam int NS = 256;

    logic          clk;
    logic          rst;
    logic          lookup_valid;
    logic          lookup_ready;
    logic [KW-1:0] lookup_key;
    logic          res_valid;
    logic          res_hit;
    logic [IW-1:0] res_id;
    logic [1:0]    res_way;
    logic          cfg_we;
    logic [2:0]    cfg_word;
    logic [31:0]   cfg_wdata;
    logic          cfg_commit;
    logic [XW-1:0] cfg_set;
    logic [1:0]    cfg_way;
    logic          cfg_flush;
    logic          cfg_cnt_clr;
    logic          cfg_busy;
    logic          cfg_err;
    logic [31:0]   hit_cnt;
    logic [31:0]   miss_cnt;

    flow_table_assoc #(
        .KEY_W(KW), .ID_W(IW), .INDEX_W(XW), .WAYS(NW)
    ) dut (
        .clk(clk), .rst(rst),
        .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
        .lookup_key(lookup_key),
        .res_valid(res_valid), .res_hit(res_hit),
        .res_id(res_id), .res_way(res_way),
        .cfg_we(cfg_we), .cfg_word(cfg_word), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .cfg_set(cfg_set), .cfg_way(cfg_way),
        .cfg_flush(cfg_flush), .cfg_cnt_clr(cfg_cnt_clr),
        .cfg_busy(cfg_busy), .cfg_err(cfg_err),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [KW-1:0] mkey [NW][NS];
    logic [IW-1:0] mid  [NW][NS];
    bit            mvld [NW][NS];
    int            busy_cnt;
    logic [KW-1:0] skey;
    logic [IW-1:0] sid;
    bit            svld;
    bit            rd_v;
    logic [KW-1:0] rd_key;
    bit            cmp_v, cmp_hit;
    logic [IW-1:0] cmp_id;
    int            cmp_way;
    bit            out_v, out_hit;
    logic [IW-1:0] out_id;
    int            out_way;
    logic [31:0]   mhit, mmiss;
    bit            merr;

    logic [KW-1:0] pool [8];

    function automatic logic [XW-1:0] hash_of(input logic [KW-1:0] k);
        logic [XW-1:0] h;
        h = '0;
        for (int i = 0; i < KW / XW; i++) h = h ^ k[i*XW +: XW];
        return h;
    endfunction

    // One clock: advance the model with the inputs currently driven,
    // then let the DUT take the edge and compare.
    task automatic tick();
        logic [XW-1:0] s;
        if (rst) begin
            busy_cnt = NS;
            rd_v = 0; cmp_v = 0; cmp_hit = 0; cmp_id = 0; cmp_way = 0;
            out_v = 0; out_hit = 0; out_id = 0; out_way = 0;
            mhit = 0; mmiss = 0; merr = 0;
            skey = 0; sid = 0; svld = 0;
        end else begin
            if (cfg_cnt_clr) begin
                mhit = 0; mmiss = 0;
            end else if (out_v) begin
                if (out_hit) begin
                    if (mhit != 32'hFFFF_FFFF) mhit = mhit + 1;
                end else if (mmiss != 32'hFFFF_FFFF) begin
                    mmiss = mmiss + 1;
                end
            end
            out_v = cmp_v; out_hit = cmp_hit; out_id = cmp_id; out_way = cmp_way;
            cmp_v = rd_v; cmp_hit = 0; cmp_id = 0; cmp_way = 0;
            if (rd_v) begin
                s = hash_of(rd_key);
                for (int w = 0; w < NW; w++) begin
                    if (!cmp_hit && mvld[w][s] && mkey[w][s] == rd_key) begin
                        cmp_hit = 1; cmp_id = mid[w][s]; cmp_way = w;
                    end
                end
            end
            rd_v   = lookup_valid && busy_cnt == 0;
            rd_key = lookup_key;
            merr = cfg_commit && (busy_cnt != 0 || int'(cfg_way) >= NW);
            if (cfg_commit && busy_cnt == 0 && int'(cfg_way) < NW) begin
                mkey[cfg_way][cfg_set] = skey;
                mid[cfg_way][cfg_set]  = sid;
                mvld[cfg_way][cfg_set] = svld;
            end
            if (busy_cnt != 0) begin
                for (int w = 0; w < NW; w++) mvld[w][NS - busy_cnt] = 0;
                busy_cnt--;
            end else if (cfg_flush) begin
                busy_cnt = NS;
            end
            if (cfg_we) begin
                if (cfg_word < 3'd4) begin
                    skey[int'(cfg_word)*32 +: 32] = cfg_wdata;
                end else if (cfg_word == 3'd4) begin
                    svld = cfg_wdata[IW];
                    sid  = cfg_wdata[IW-1:0];
                end
            end
        end
        @(posedge clk);
        #1;
        check("lookup_ready", {63'd0, lookup_ready}, {63'd0, busy_cnt == 0});
        check("cfg_busy", {63'd0, cfg_busy}, {63'd0, busy_cnt != 0});
        check("res_valid", {63'd0, res_valid}, {63'd0, out_v});
        if (out_v || rst) begin
            check("res_hit", {63'd0, res_hit}, {63'd0, out_hit});
            check("res_id", 64'(res_id), 64'(out_id));
            check("res_way", 64'(res_way), 64'(out_way));
        end
        check("hit_cnt", 64'(hit_cnt), 64'(mhit));
        check("miss_cnt", 64'(miss_cnt), 64'(mmiss));
        check("cfg_err", {63'd0, cfg_err}, {63'd0, merr});
    endtask

    task automatic quiet();
        lookup_valid = 0; cfg_we = 0; cfg_commit = 0;
        cfg_flush = 0; cfg_cnt_clr = 0;
    endtask

    task automatic idle(input int n);
        quiet();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic stage(input logic [KW-1:0] k, input logic [IW-1:0] id,
                         input bit v);
        quiet();
        cfg_we = 1;
        for (int i = 0; i < 4; i++) begin
            cfg_word = 3'(i); cfg_wdata = k[i*32 +: 32]; tick();
        end
        cfg_word = 3'd4; cfg_wdata = {15'd0, v, id}; tick();
        cfg_we = 0;
    endtask

    task automatic commit(input logic [XW-1:0] st, input logic [1:0] wy);
        quiet();
        cfg_commit = 1; cfg_set = st; cfg_way = wy; tick();
        cfg_commit = 0;
    endtask

    task automatic lookup(input logic [KW-1:0] k);
        quiet();
        lookup_valid = 1; lookup_key = k; tick();
        lookup_valid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        quiet();
        while (cfg_busy && n < 400) begin
            tick(); n++;
        end
        check("flush_done", {63'd0, cfg_busy}, 64'd0);
    endtask

    int          busy_seen;
    logic [31:0] h0, m0;

    initial begin
        pool[0] = 128'h42;   pool[1] = 128'h4200; pool[2] = 128'h4242;
        pool[3] = 128'h0101; pool[4] = 128'h13;   pool[5] = 128'h1300;
        pool[6] = 128'h0;    pool[7] = 128'h55;
        quiet();
        cfg_word = 0; cfg_wdata = 0; cfg_set = 0; cfg_way = 0;
        rst = 1; lookup_valid = 1; lookup_key = 128'h1234;
        tick(); tick();
        rst = 0;
        busy_seen = 0;
        while (cfg_busy && busy_seen < 400) begin
            tick(); busy_seen++;
        end
        check("flush_len", 64'(busy_seen), 64'd256);
        tick();
        lookup_valid = 0;
        idle(2);
        check("first_lat", {63'd0, res_valid}, 64'd1);
        check("first_hit", {63'd0, res_hit}, 64'd0);
        idle(1);
        check("first_miss_cnt", 64'(miss_cnt), 64'd1);

        stage(128'h42, 16'h0007, 1);
        commit(8'h42, 2'd0);
        lookup(128'h42);
        idle(2);
        check("k42_valid", {63'd0, res_valid}, 64'd1);
        check("k42_id", 64'(res_id), 64'h7);
        check("k42_way", 64'(res_way), 64'd0);

        stage(128'h4200, 16'h0009, 1);
        commit(8'h42, 2'd1);
        lookup(128'h4200);
        idle(2);
        check("k4200_id", 64'(res_id), 64'h9);
        check("k4200_way", 64'(res_way), 64'd1);
        lookup(128'h4242);
        idle(2);
        check("k4242_miss", {63'd0, res_hit}, 64'd0);
        idle(1);

        h0 = mhit; m0 = mmiss;
        quiet();
        for (int i = 0; i < 10; i++) begin
            lookup_valid = 1;
            lookup_key = (i % 2 == 0) ? 128'h42 : 128'h4242;
            tick();
        end
        idle(4);
        check("b2b_hits", 64'(hit_cnt), 64'(h0 + 5));
        check("b2b_miss", 64'(miss_cnt), 64'(m0 + 5));

        commit(8'h42, 2'd2);
        check("err_way", {63'd0, cfg_err}, 64'd1);
        idle(1);
        check("err_pulse", {63'd0, cfg_err}, 64'd0);
        lookup(128'h42);
        idle(3);

        quiet();
        cfg_flush = 1; tick();
        commit(8'h42, 2'd0);
        check("err_flush", {63'd0, cfg_err}, 64'd1);
        wait_idle();
        lookup(128'h42);
        quiet();
        tick(); tick();
        check("flushed_miss", {63'd0, res_hit}, 64'd0);
        cfg_cnt_clr = 1; tick();
        cfg_cnt_clr = 0; tick();
        check("clr_hit", 64'(hit_cnt), 64'd0);
        check("clr_miss", 64'(miss_cnt), 64'd0);

        stage(128'h42, 16'h0007, 1);
        commit(8'h42, 2'd0);
        stage(128'h42, 16'h000A, 1);
        lookup(128'h42);
        commit(8'h42, 2'd0);
        idle(1);
        check("rf_old", 64'(res_id), 64'h7);
        lookup(128'h42);
        idle(2);
        check("rf_new", 64'(res_id), 64'hA);

        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 999) == 0);
            lookup_valid = ($urandom_range(0, 3) != 0);
            lookup_key   = pool[$urandom_range(0, 7)];
            cfg_we       = ($urandom_range(0, 2) == 0);
            cfg_word     = 3'($urandom_range(0, 7));
            if (cfg_word == 3'd0) cfg_wdata = pool[$urandom_range(0, 7)][31:0];
            else if (cfg_word == 3'd4)
                cfg_wdata = ($urandom_range(0, 3) != 0 ? 32'h1_0000 : 32'h0)
                            | 32'($urandom_range(0, 15));
            else if (cfg_word < 3'd4)
                cfg_wdata = ($urandom_range(0, 15) == 0) ? $urandom : 32'h0;
            else cfg_wdata = $urandom;
            cfg_commit   = ($urandom_range(0, 5) == 0);
            cfg_set      = hash_of(pool[$urandom_range(0, 7)]);
            cfg_way      = 2'($urandom_range(0, 3));
            cfg_flush    = ($urandom_range(0, 399) == 0);
            cfg_cnt_clr  = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
